// File: rtl/button_pkg.sv
// button_pkg: shared constants and helpers for the button_bank push-button front end.
package button_pkg;

    // Level a channel rests at when no button is pressed (after polarity normalisation).
    localparam logic BTN_RELEASED = 1'b0;

    // Default counts for a 100 MHz clock: 10 ms debounce, 1 s long press.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 100_000_000;

    // Counter width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_bank_if.sv
// button_bank_if: raw button pins in, debounced level and event pulses out.
interface button_bank_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_i;
    logic [NUM_BTN-1:0] level_o;
    logic [NUM_BTN-1:0] press_o;
    logic [NUM_BTN-1:0] release_o;
    logic [NUM_BTN-1:0] toggle_o;
    logic [NUM_BTN-1:0] long_o;

    // Board / stimulus side: drives the pins, consumes the clean events.
    modport master (
        output btn_i,
        input  level_o, press_o, release_o, toggle_o, long_o
    );

    // button_bank side.
    modport slave (
        input  btn_i,
        output level_o, press_o, release_o, toggle_o, long_o
    );
endinterface

// File: rtl/button_chan.sv
// button_chan: one button channel -- synchroniser, debounce, edge pulses, toggle latch
// and, when BUTTON_BANK_LONG_PRESS_EN is defined, the long-press hold counter.
module button_chan
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o,
    output logic long_o
);
    localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= BTN_RELEASED;
            s2_q <= BTN_RELEASED;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // Debounce: a new level is accepted only after an unbroken run of mismatching samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            accept  = 1'b1;
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d   = accept & s2_q;
        release_d = accept & ~s2_q;
        toggle_d  = toggle_q ^ press_d;
    end

    // Debounce state and event registers; pulses land on the same edge as the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= BTN_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign toggle_o  = toggle_q;

`ifdef BUTTON_BANK_LONG_PRESS_EN
    localparam int            HW        = cnt_w(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter runs while pressed and parks at the threshold so the pulse fires once.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HOLD_FIRE);
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    // Long-press feature compiled out; LONG_CYCLES has no effect in this build.
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// button_bank: NUM_BTN independent debounced button channels behind button_bank_if.
// Optional long-press pulse is built only when BUTTON_BANK_LONG_PRESS_EN is defined.
module button_bank
    import button_pkg::*;
#(
    parameter int   NUM_BTN         = 2,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter logic BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    button_bank_if.slave   bus
);
    logic [NUM_BTN-1:0] btn_norm;
    logic [NUM_BTN-1:0] level_w, press_w, release_w, toggle_w, long_w;

    // Normalise polarity before synchronisation so every channel sees 1 = pressed.
    assign btn_norm = bus.btn_i ^ {NUM_BTN{BTN_ACTIVE_LOW}};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_i     (btn_norm[g]),
            .level_o   (level_w[g]),
            .press_o   (press_w[g]),
            .release_o (release_w[g]),
            .toggle_o  (toggle_w[g]),
            .long_o    (long_w[g])
        );
    end

    assign bus.level_o   = level_w;
    assign bus.press_o   = press_w;
    assign bus.release_o = release_w;
    assign bus.toggle_o  = toggle_w;
    assign bus.long_o    = long_w;

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed checks of button_bank with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Long-press expectations follow whether BUTTON_BANK_LONG_PRESS_EN is defined.
module tb_button_bank;
    localparam int NB = 2;
    localparam int DC = 4;
    localparam int LC = 10;
`ifdef BUTTON_BANK_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    button_bank_if #(.NUM_BTN(NB)) bus ();

    button_bank #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC),
        .BTN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // Channel outputs packed as {long, toggle, release, press, level}.
    function automatic logic [4:0] ch(input int c);
        return {bus.long_o[c], bus.toggle_o[c], bus.release_o[c], bus.press_o[c], bus.level_o[c]};
    endfunction

    function automatic logic [4:0] pk(input logic lg, input logic tg, input logic rl,
                                      input logic pr, input logic lv);
        return {lg, tg, rl, pr, lv};
    endfunction

    initial begin
        // Reset with buttons released.
        bus.btn_i = '0;
        rst_n     = 1'b0;
        repeat (3) tick();
        chk("reset_all", 0, {22'd0, bus.long_o, bus.toggle_o, bus.release_o, bus.press_o, bus.level_o}, 32'd0);

        // Clean press on ch0, held long enough for a long pulse at press+9.
        bus.btn_i[0] = 1'b1;
        rst_n        = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk("press0", e, 32'(ch(0)), 32'(pk(LONG_EN && e == 15, e >= 6, 1'b0, e == 6, e >= 6)));
            chk("idle1", e, 32'(ch(1)), 32'd0);
        end

        // Release ch0: release pulse 6 edges later, toggle keeps its value.
        bus.btn_i[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("release0", e, 32'(ch(0)), 32'(pk(1'b0, 1'b1, e == 6, 1'b0, e < 6)));
        end

        // Bounce on ch1: high 3 samples, low 1, then steady high.
        for (int e = 1; e <= 40; e++) begin
            bus.btn_i[1] = (e != 4);
            tick();
            chk("bounce1", e, 32'(ch(1)), 32'(pk(LONG_EN && e == 19, e >= 10, 1'b0, e == 10, e >= 10)));
            chk("quiet0", e, 32'(ch(0)), 32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        end

        // Release ch1.
        bus.btn_i[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("release1", e, 32'(ch(1)), 32'(pk(1'b0, 1'b1, e == 6, 1'b0, e < 6)));
        end

        // Short press on ch0: level falls before the hold threshold, so no long pulse.
        for (int e = 1; e <= 20; e++) begin
            bus.btn_i[0] = (e <= 7);
            tick();
            chk("short0", e, 32'(ch(0)), 32'(pk(1'b0, e < 6, e == 13, e == 6, e >= 6 && e <= 12)));
        end

        // Next press on ch0 flips toggle back; keep holding into a reset.
        bus.btn_i[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("repress0", e, 32'(ch(0)), 32'(pk(1'b0, e >= 6, 1'b0, e == 6, e >= 6)));
        end

        // Reset mid-hold: everything clears.
        rst_n = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            chk("midrst", e, {22'd0, bus.long_o, bus.toggle_o, bus.release_o, bus.press_o, bus.level_o}, 32'd0);
        end

        // Held button re-detected as a fresh press after full latency.
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("redetect0", e, 32'(ch(0)), 32'(pk(LONG_EN && e == 15, e >= 6, 1'b0, e == 6, e >= 6)));
            chk("redetect1", e, 32'(ch(1)), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
